// File: rtl/ux607_hclkgen_pkg.sv
// Shared definitions for the HCLK generator register block and its programming sequencer.
package ux607_hclkgen_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_W    = 5;
    localparam int unsigned M_W    = 8;
    localparam int unsigned OD_W   = 2;
    localparam int unsigned DIV_W  = 6;

    localparam logic [ADDR_W-1:0] HFXOSCCFG_OFS = 12'h004;
    localparam logic [ADDR_W-1:0] PLLCFG_OFS    = 12'h008;
    localparam logic [ADDR_W-1:0] PLLOUTDIV_OFS = 12'h00C;

    localparam int unsigned HFXOSC_EN_BIT  = 30;
    localparam int unsigned PLL_RESET_BIT  = 30;
    localparam int unsigned PLL_ASLEEP_BIT = 29;
    localparam int unsigned PLL_BYPASS_BIT = 18;
    localparam int unsigned PLL_OD_LSB     = 13;
    localparam int unsigned PLL_M_LSB      = 5;
    localparam int unsigned PLL_N_LSB      = 0;
    localparam int unsigned OUT_DIVBY1_BIT = 8;
    localparam int unsigned OUT_DIV_LSB    = 0;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LOCK = 2'd1;
    localparam logic [1:0] ERR_VFY  = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OSC_WR,
        ST_RST_WR,
        ST_RST_WAIT,
        ST_REL_WR,
        ST_LOCK_WAIT,
        ST_DIV_WR,
        ST_SW_WR,
        ST_VFY_RD,
        ST_DONE,
        ST_ERR
    } seq_state_e;

    typedef struct packed {
        logic [N_W-1:0]   n;
        logic [M_W-1:0]   m;
        logic [OD_W-1:0]  od;
        logic [DIV_W-1:0] outdiv;
        logic             divby1;
    } pll_cfg_t;

    function automatic logic [DATA_W-1:0] hfxosccfg_word();
        logic [DATA_W-1:0] w;
        w = '0;
        w[HFXOSC_EN_BIT] = 1'b1;
        return w;
    endfunction

    // ASLEEP is always written 0: the sequencer never parks the PLL asleep.
    function automatic logic [DATA_W-1:0] pllcfg_word(pll_cfg_t c, logic rst_en, logic byp);
        logic [DATA_W-1:0] w;
        w = '0;
        w[PLL_RESET_BIT]          = rst_en;
        w[PLL_ASLEEP_BIT]         = 1'b0;
        w[PLL_BYPASS_BIT]         = byp;
        w[PLL_OD_LSB +: OD_W]     = c.od;
        w[PLL_M_LSB +: M_W]       = c.m;
        w[PLL_N_LSB +: N_W]       = c.n;
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] plloutdiv_word(pll_cfg_t c);
        logic [DATA_W-1:0] w;
        w = '0;
        w[OUT_DIVBY1_BIT]         = c.divby1;
        w[OUT_DIV_LSB +: DIV_W]   = c.outdiv;
        return w;
    endfunction

endpackage

// File: rtl/ux607_icb_single_mst.sv
// Single-outstanding ICB access engine: one launch pulse issues one command and
// waits for its response; completion is reported as a combinational pulse.
module ux607_icb_single_mst
    import ux607_hclkgen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              launch,
    input  logic [ADDR_W-1:0] launch_addr,
    input  logic              launch_read,
    input  logic [DATA_W-1:0] launch_wdata,
    output logic              cmp_c,
    output logic [DATA_W-1:0] rdata_c,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              cmd_read,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [DATA_W-1:0] rsp_rdata
);

    // A response only counts once its command has been accepted (possibly this cycle).
    assign cmp_c   = rsp_valid & rsp_ready & (~cmd_valid | cmd_ready);
    assign rdata_c = rsp_rdata;

    // cmd_valid and rsp_ready rise together; the responder's cmd_ready follows rsp_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            rsp_ready <= 1'b0;
            cmd_addr  <= '0;
            cmd_read  <= 1'b0;
            cmd_wdata <= '0;
        end else if (launch) begin
            cmd_valid <= 1'b1;
            rsp_ready <= 1'b1;
            cmd_addr  <= launch_addr;
            cmd_read  <= launch_read;
            cmd_wdata <= launch_wdata;
        end else begin
            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
            if (cmp_c) begin
                rsp_ready <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ux607_pllcfg_seq.sv
// Autonomous PLL programming sequencer: oscillator on, PLL reset in bypass, lock wait,
// output divider, bypass removal, readback verify, all over a single-outstanding ICB port.
module ux607_pllcfg_seq
    import ux607_hclkgen_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_W-1:0]    cfg_n,
    input  logic [M_W-1:0]    cfg_m,
    input  logic [OD_W-1:0]   cfg_od,
    input  logic [DIV_W-1:0]  cfg_outdiv,
    input  logic              cfg_outdivby1,
    input  logic              pll_lock,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              o_icb_cmd_valid,
    input  logic              o_icb_cmd_ready,
    output logic [ADDR_W-1:0] o_icb_cmd_addr,
    output logic              o_icb_cmd_read,
    output logic [DATA_W-1:0] o_icb_cmd_wdata,
    input  logic              o_icb_rsp_valid,
    output logic              o_icb_rsp_ready,
    input  logic [DATA_W-1:0] o_icb_rsp_rdata
);

    localparam logic [DATA_W-1:0] VFY_MASK = 32'h7FFF_FFFF;

    seq_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    pll_cfg_t          cfg, cfg_nxt;
    logic              err_nxt, busy_nxt, done_nxt;
    logic [1:0]        err_code_nxt;
    logic              is_acc, launch_c, cmp_c;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_read;
    logic [DATA_W-1:0] acc_wdata, rdata_c, sw_word;

    ux607_icb_single_mst u_mst (
        .clk          (clk),
        .rst          (rst),
        .launch       (launch_c),
        .launch_addr  (acc_addr),
        .launch_read  (acc_read),
        .launch_wdata (acc_wdata),
        .cmp_c        (cmp_c),
        .rdata_c      (rdata_c),
        .cmd_valid    (o_icb_cmd_valid),
        .cmd_ready    (o_icb_cmd_ready),
        .cmd_addr     (o_icb_cmd_addr),
        .cmd_read     (o_icb_cmd_read),
        .cmd_wdata    (o_icb_cmd_wdata),
        .rsp_valid    (o_icb_rsp_valid),
        .rsp_ready    (o_icb_rsp_ready),
        .rsp_rdata    (o_icb_rsp_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cfg      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cfg      <= cfg_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            err_code <= err_code_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cfg_nxt      = cfg;
        err_nxt      = err;
        err_code_nxt = err_code;
        sw_word      = pllcfg_word(cfg, 1'b0, 1'b0);

        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    cfg_nxt.n      = cfg_n;
                    cfg_nxt.m      = cfg_m;
                    cfg_nxt.od     = cfg_od;
                    cfg_nxt.outdiv = cfg_outdiv;
                    cfg_nxt.divby1 = cfg_outdivby1;
                    err_nxt        = 1'b0;
                    err_code_nxt   = ERR_NONE;
                    state_nxt      = ST_OSC_WR;
                end
            end
            ST_OSC_WR: if (cmp_c) state_nxt = ST_RST_WR;
            ST_RST_WR: begin
                if (cmp_c) begin
                    state_nxt = ST_RST_WAIT;
                    cnt_nxt   = CNT_W'(RST_CYCLES - 1);
                end
            end
            ST_RST_WAIT: begin
                if (cnt == '0) state_nxt = ST_REL_WR;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            ST_REL_WR: begin
                if (cmp_c) begin
                    state_nxt = ST_LOCK_WAIT;
                    cnt_nxt   = CNT_W'(LOCK_TIMEOUT - 1);
                end
            end
            // Timeout leaves the PLL in bypass and issues no further accesses.
            ST_LOCK_WAIT: begin
                if (pll_lock) begin
                    state_nxt = ST_DIV_WR;
                end else if (cnt == '0) begin
                    state_nxt    = ST_ERR;
                    err_nxt      = 1'b1;
                    err_code_nxt = ERR_LOCK;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_DIV_WR: if (cmp_c) state_nxt = ST_SW_WR;
            ST_SW_WR:  if (cmp_c) state_nxt = ST_VFY_RD;
            ST_VFY_RD: begin
                if (cmp_c) begin
                    if (((rdata_c ^ sw_word) & VFY_MASK) == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt    = ST_ERR;
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_VFY;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Access payload for the state being entered, launched on the transition.
        is_acc    = 1'b1;
        acc_addr  = PLLCFG_OFS;
        acc_read  = 1'b0;
        acc_wdata = '0;
        case (state_nxt)
            ST_OSC_WR: begin
                acc_addr  = HFXOSCCFG_OFS;
                acc_wdata = hfxosccfg_word();
            end
            ST_RST_WR: acc_wdata = pllcfg_word(cfg_nxt, 1'b1, 1'b1);
            ST_REL_WR: acc_wdata = pllcfg_word(cfg_nxt, 1'b0, 1'b1);
            ST_DIV_WR: begin
                acc_addr  = PLLOUTDIV_OFS;
                acc_wdata = plloutdiv_word(cfg_nxt);
            end
            ST_SW_WR:  acc_wdata = pllcfg_word(cfg_nxt, 1'b0, 1'b0);
            ST_VFY_RD: acc_read  = 1'b1;
            default:   is_acc    = 1'b0;
        endcase
        launch_c = is_acc && (state_nxt != state);

        busy_nxt = !(state_nxt inside {ST_IDLE, ST_DONE, ST_ERR});
        done_nxt = (state == ST_VFY_RD) && (state_nxt == ST_DONE);
    end

endmodule

// File: tb/tb_ux607_pllcfg_seq.sv
// Scoreboard bench for ux607_pllcfg_seq: stimulus pushes expected ICB accesses,
// a negedge monitor pops and compares them as the DUT issues commands.
module tb_ux607_pllcfg_seq;

    localparam int unsigned RST_CYC = 4;
    localparam int unsigned LOCK_TO = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  cfg_n = '0;
    logic [7:0]  cfg_m = '0;
    logic [1:0]  cfg_od = '0;
    logic [5:0]  cfg_outdiv = '0;
    logic        cfg_outdivby1 = 1'b0;
    logic        pll_lock = 1'b1;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic        cmd_valid, cmd_ready, cmd_read, rsp_valid, rsp_ready;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata, rsp_rdata;

    always #5 clk = ~clk;

    ux607_pllcfg_seq #(.RST_CYCLES(RST_CYC), .LOCK_TIMEOUT(LOCK_TO), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_n           (cfg_n),
        .cfg_m           (cfg_m),
        .cfg_od          (cfg_od),
        .cfg_outdiv      (cfg_outdiv),
        .cfg_outdivby1   (cfg_outdivby1),
        .pll_lock        (pll_lock),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .err_code        (err_code),
        .o_icb_cmd_valid (cmd_valid),
        .o_icb_cmd_ready (cmd_ready),
        .o_icb_cmd_addr  (cmd_addr),
        .o_icb_cmd_read  (cmd_read),
        .o_icb_cmd_wdata (cmd_wdata),
        .o_icb_rsp_valid (rsp_valid),
        .o_icb_rsp_ready (rsp_ready),
        .o_icb_rsp_rdata (rsp_rdata)
    );

    // Responder: mode 0 zero-latency; mode 1 stalls cmd_ready 3 cycles, response 2 cycles later.
    bit          mode = 1'b0;
    logic [31:0] rd_val = '0;
    logic        pend;
    int          wcnt, dly;

    assign cmd_ready = mode ? (rsp_ready && !pend && wcnt == 3) : rsp_ready;
    assign rsp_valid = mode ? (pend && dly == 2) : cmd_valid;
    assign rsp_rdata = rd_val;

    always @(posedge clk) begin
        if (rst || !mode) begin
            pend <= 1'b0;
            wcnt <= 0;
            dly  <= 0;
        end else begin
            if (pend) begin
                if (dly < 2) dly <= dly + 1;
                else if (rsp_ready) pend <= 1'b0;
            end
            if (cmd_valid && !pend) begin
                if (cmd_ready) begin
                    pend <= 1'b1;
                    dly  <= 0;
                    wcnt <= 0;
                end else if (wcnt < 3) begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    typedef struct {
        logic [11:0] addr;
        logic        rd;
        logic [31:0] wdata;
    } acc_t;

    acc_t exp_q[$];
    int   ntests = 0;
    int   nfail = 0;
    int   gaps[8];
    int   acc_idx = 0;
    int   lowrun = 0;
    int   since_hs = 0;
    int   err_lat = -1;
    int   done_cnt = 0;
    logic err_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with cmd_valid is compared against the queue head.
    always @(negedge clk) begin
        acc_t e;
        if (rst) begin
            lowrun   = 0;
            since_hs = 0;
            err_prev = 1'b0;
        end else begin
            if (start && !busy) acc_idx = 0;
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    ntests++;
                    nfail++;
                    $display("FAIL unexpected_access: addr %h read %b wdata %h, required no access",
                             cmd_addr, cmd_read, cmd_wdata);
                end else begin
                    e = exp_q[0];
                    chk(cmd_ready ? "acc_addr" : "stall_addr", 32'(cmd_addr), 32'(e.addr));
                    chk(cmd_ready ? "acc_read" : "stall_read", 32'(cmd_read), 32'(e.rd));
                    if (!e.rd) chk(cmd_ready ? "acc_wdata" : "stall_wdata", cmd_wdata, e.wdata);
                    if (cmd_ready) begin
                        void'(exp_q.pop_front());
                        if (acc_idx < 8) gaps[acc_idx] = lowrun;
                        acc_idx++;
                        lowrun = 0;
                    end
                end
            end else begin
                lowrun++;
            end
            since_hs = (cmd_valid && cmd_ready) ? 0 : since_hs + 1;
            if (err && !err_prev) err_lat = since_hs;
            err_prev = err;
            if (done) done_cnt++;
        end
    end

    task automatic push_acc(input logic [11:0] a, input logic r, input logic [31:0] w);
        acc_t e;
        e.addr  = a;
        e.rd    = r;
        e.wdata = w;
        exp_q.push_back(e);
    endtask

    task automatic push_head(input logic [31:0] rst_w, input logic [31:0] rel_w);
        push_acc(12'h004, 1'b0, 32'h4000_0000);
        push_acc(12'h008, 1'b0, rst_w);
        push_acc(12'h008, 1'b0, rel_w);
    endtask

    task automatic push_full(input logic [31:0] rst_w, input logic [31:0] rel_w,
                             input logic [31:0] div_w, input logic [31:0] sw_w);
        push_head(rst_w, rel_w);
        push_acc(12'h00C, 1'b0, div_w);
        push_acc(12'h008, 1'b0, sw_w);
        push_acc(12'h008, 1'b1, 32'h0);
    endtask

    // Config A: N=01 M=F2 OD=2 div=03 by1=0 -> pllcfg low half 0x5E41, outdiv 0x003
    task automatic push_a();
        push_full(32'h4004_5E41, 32'h0004_5E41, 32'h0000_0003, 32'h0000_5E41);
    endtask

    // Config B: N=1F M=01 OD=1 div=2A by1=1 -> pllcfg low half 0x203F, outdiv 0x12A
    task automatic push_b();
        push_full(32'h4004_203F, 32'h0004_203F, 32'h0000_012A, 32'h0000_203F);
    endtask

    task automatic do_start(input logic [4:0] n, input logic [7:0] m, input logic [1:0] od,
                            input logic [5:0] dv, input logic d1);
        @(posedge clk); #1;
        start = 1'b1;
        cfg_n = n; cfg_m = m; cfg_od = od; cfg_outdiv = dv; cfg_outdivby1 = d1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("err_after_start", 32'(err), 32'd0);
        chk("err_code_after_start", 32'(err_code), 32'd0);
    endtask

    task automatic start_a();
        do_start(5'h01, 8'hF2, 2'b10, 6'h03, 1'b0);
    endtask

    task automatic start_b();
        do_start(5'h1F, 8'h01, 2'b01, 6'h2A, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        ntests++;
        if (busy) begin
            nfail++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int d0;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
        chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        chk("rst_cmd_wdata", cmd_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero-latency responder; readback bit31 set must be ignored
        mode = 1'b0; pll_lock = 1'b1; rd_val = 32'h8000_5E41;
        d0 = done_cnt;
        push_a();
        start_a();
        wait_idle("t1");
        chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_queue_left", 32'(exp_q.size()), 32'd0);
        chk("t1_rst_wait_gap", 32'(gaps[2]), 32'(RST_CYC));
        chk("t1_lock_gap", 32'(gaps[3]), 32'd1);

        // Stalling responder
        mode = 1'b1; rd_val = 32'h0000_5E41;
        d0 = done_cnt;
        push_a();
        start_a();
        wait_idle("t2");
        chk("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t2_err", 32'(err), 32'd0);
        chk("t2_queue_left", 32'(exp_q.size()), 32'd0);

        // Lock timeout
        mode = 1'b0; pll_lock = 1'b0;
        d0 = done_cnt;
        push_head(32'h4004_5E41, 32'h0004_5E41);
        start_a();
        wait_idle("t3");
        repeat (10) @(negedge clk);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_err_code", 32'(err_code), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_err_latency", 32'(err_lat), 32'(LOCK_TO + 1));
        chk("t3_done_pulses", 32'(done_cnt - d0), 32'd0);
        chk("t3_queue_left", 32'(exp_q.size()), 32'd0);
        pll_lock = 1'b1;

        // Readback mismatch (bypass stuck), then a clean rerun clears err
        rd_val = 32'h0004_5E41;
        d0 = done_cnt;
        push_a();
        start_a();
        wait_idle("t4");
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_err_code", 32'(err_code), 32'd2);
        chk("t4_done_pulses", 32'(done_cnt - d0), 32'd0);
        chk("t4_queue_left", 32'(exp_q.size()), 32'd0);
        rd_val = 32'h0000_5E41;
        d0 = done_cnt;
        push_a();
        start_a();
        wait_idle("t4b");
        chk("t4b_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t4b_err", 32'(err), 32'd0);

        // Second start with other cfg while busy is ignored
        d0 = done_cnt;
        push_a();
        start_a();
        repeat (5) @(posedge clk);
        start_b();
        wait_idle("t5");
        chk("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_queue_left", 32'(exp_q.size()), 32'd0);

        // Reset during the stalled divider write, then a full rerun
        mode = 1'b1; rd_val = 32'h0000_203F;
        push_b();
        start_b();
        n = 0;
        while (!(cmd_valid && cmd_addr == 12'h00C) && n < 400) begin
            @(negedge clk);
            n++;
        end
        ntests++;
        if (!(cmd_valid && cmd_addr == 12'h00C)) begin
            nfail++;
            $display("FAIL t6_div_wait: cmd_valid=%b addr=%h, required 1 / 00c", cmd_valid, cmd_addr);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("t6_rsp_ready", 32'(rsp_ready), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_err_code", 32'(err_code), 32'd0);
        chk("t6_cmd_addr", 32'(cmd_addr), 32'd0);
        mode = 1'b0;
        d0 = done_cnt;
        push_b();
        start_b();
        wait_idle("t6b");
        chk("t6b_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t6b_err", 32'(err), 32'd0);
        chk("t6b_queue_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
